// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/funct encodings and ALU operation set
// shared by the single-cycle MIPS-subset core.
package cpu_pkg;

    localparam int REG_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_XNOR  = 6'b111111;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_NOR,
        ALU_XNOR,
        ALU_SLT
    } alu_op_e;

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational 32-bit ALU with zero flag
// (the zero flag drives beq/bne resolution).
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     alu_op,
    output logic [31:0] result,
    output logic        zero
);

    always_comb begin
        result = '0;
        unique case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_XNOR: result = ~(a ^ b);
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            default:  result = '0;
        endcase
    end

    assign zero = (result == 32'd0);

endmodule

// File: rtl/cpu.sv
// cpu: single-cycle MIPS-subset core with register file,
// PC logic and debug views reg_a/reg_b/reg_c.
module cpu
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] i_datain,
    output logic [31:0] i_addr,
    input  logic [31:0] d_datain,
    output logic [31:0] d_addr,
    output logic        d_we,
    output logic [31:0] d_dataout
);

    logic [31:0] pc_q, pc_d, pc_nxt, pc_plus4;
    logic [31:0] reg_a_q, reg_a_d;
    logic [31:0] reg_b_q, reg_b_d;
    logic [31:0] reg_c_q, reg_c_d;
    logic [31:0] gr_q [NUM_REGS];
    logic [31:0] gr_d [NUM_REGS];

    logic [5:0]       opcode, funct;
    logic [REG_W-1:0] rs, rt, rd, wr_idx;
    logic [15:0]      imm;
    logic [31:0]      sext, zext, rs_val, rt_val;
    logic [31:0]      alu_b, alu_res, wr_data, c_val;
    logic [31:0]      br_tgt, j_tgt;
    logic             alu_zero, wr_en, is_lw, is_sw;
    alu_op_e          alu_op;

    assign opcode   = i_datain[31:26];
    assign rs       = i_datain[25:21];
    assign rt       = i_datain[20:16];
    assign rd       = i_datain[15:11];
    assign funct    = i_datain[5:0];
    assign imm      = i_datain[15:0];
    assign sext     = {{16{imm[15]}}, imm};
    assign zext     = {16'b0, imm};
    assign rs_val   = gr_q[rs];
    assign rt_val   = gr_q[rt];
    assign pc_plus4 = pc_q + 32'd4;
    assign br_tgt   = pc_plus4 + {sext[29:0], 2'b00};
    assign j_tgt    = {pc_plus4[31:28], i_datain[25:0], 2'b00};

    cpu_alu u_alu (
        .a      (rs_val),
        .b      (alu_b),
        .alu_op (alu_op),
        .result (alu_res),
        .zero   (alu_zero)
    );

    always_comb begin
        alu_op  = ALU_ADD;
        alu_b   = rt_val;
        wr_en   = 1'b0;
        wr_idx  = rd;
        wr_data = alu_res;
        c_val   = alu_res;
        pc_nxt  = pc_plus4;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        unique case (opcode)
            OP_RTYPE: begin
                wr_en = 1'b1;
                unique case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_XNOR: alu_op = ALU_XNOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_JR: begin
                        wr_en  = 1'b0;
                        pc_nxt = rs_val;
                        c_val  = rs_val;
                    end
                    default: wr_en = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                alu_b  = sext;
                wr_en  = 1'b1;
                wr_idx = rt;
            end
            OP_ANDI: begin
                alu_op = ALU_AND;
                alu_b  = zext;
                wr_en  = 1'b1;
                wr_idx = rt;
            end
            OP_ORI: begin
                alu_op = ALU_OR;
                alu_b  = zext;
                wr_en  = 1'b1;
                wr_idx = rt;
            end
            OP_LW: begin
                alu_b   = sext;
                is_lw   = 1'b1;
                wr_en   = 1'b1;
                wr_idx  = rt;
                wr_data = d_datain;
                c_val   = d_datain;
            end
            OP_SW: begin
                alu_b = sext;
                is_sw = 1'b1;
            end
            OP_BEQ: begin
                alu_op = ALU_SUB;
                if (alu_zero) pc_nxt = br_tgt;
            end
            OP_BNE: begin
                alu_op = ALU_SUB;
                if (!alu_zero) pc_nxt = br_tgt;
            end
            OP_J: begin
                pc_nxt = j_tgt;
                c_val  = j_tgt;
            end
            OP_JAL: begin
                pc_nxt  = j_tgt;
                c_val   = j_tgt;
                wr_en   = 1'b1;
                wr_idx  = REG_W'(31);
                wr_data = pc_plus4;
            end
            default: ;
        endcase
    end

    // Everything holds unless start; gr0 is never written.
    always_comb begin
        pc_d    = pc_q;
        reg_a_d = reg_a_q;
        reg_b_d = reg_b_q;
        reg_c_d = reg_c_q;
        gr_d    = gr_q;
        if (start) begin
            pc_d    = pc_nxt;
            reg_a_d = rs_val;
            reg_b_d = alu_b;
            reg_c_d = c_val;
            if (wr_en && wr_idx != '0) gr_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            reg_a_q <= '0;
            reg_b_q <= '0;
            reg_c_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) gr_q[i] <= '0;
        end else begin
            pc_q    <= pc_d;
            reg_a_q <= reg_a_d;
            reg_b_q <= reg_b_d;
            reg_c_q <= reg_c_d;
            gr_q    <= gr_d;
        end
    end

    assign i_addr    = pc_q;
    assign d_addr    = (is_lw || is_sw) ? alu_res : 32'd0;
    assign d_we      = is_sw && start;
    assign d_dataout = is_sw ? rt_val : 32'd0;

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed program for the single-cycle core; expectations
// are queued by the stimulus and checked by a negedge monitor.
module tb_cpu;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        reset, start;
    logic [31:0] i_datain, d_datain;
    logic [31:0] i_addr, d_addr, d_dataout;
    logic        d_we;

    cpu dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .i_datain  (i_datain),
        .i_addr    (i_addr),
        .d_datain  (d_datain),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_dataout (d_dataout)
    );

    always #5 clock = ~clock;

    localparam int S_PC = 0, S_DA = 1, S_WE = 2, S_DO = 3;
    localparam int S_GR = 100, S_RA = 200, S_RB = 201, S_RC = 202;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t sbq[$];
    chk_t mon_c;
    int   tests = 0;
    int   fails = 0;
    logic [31:0] exp_pc;

    function automatic logic [31:0] observe(int sel);
        if (sel >= S_GR && sel < S_GR + 32) return dut.gr_q[sel - S_GR];
        case (sel)
            S_PC:    return i_addr;
            S_DA:    return d_addr;
            S_WE:    return {31'b0, d_we};
            S_DO:    return d_dataout;
            S_RA:    return dut.reg_a_q;
            S_RB:    return dut.reg_b_q;
            S_RC:    return dut.reg_c_q;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [31:0] enc_r(logic [5:0] f, logic [4:0] rs,
                                          logic [4:0] rt, logic [4:0] rd);
        return {OP_RTYPE, rs, rt, rd, 5'b0, f};
    endfunction

    function automatic logic [31:0] enc_i(logic [5:0] op, logic [4:0] rs,
                                          logic [4:0] rt, logic [15:0] im);
        return {op, rs, rt, im};
    endfunction

    function automatic logic [31:0] enc_j(logic [5:0] op, logic [25:0] a);
        return {op, a};
    endfunction

    task automatic push(string n, int sel, logic [31:0] e);
        sbq.push_back('{n, sel, e});
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic exec(logic [31:0] ins, logic [31:0] din);
        i_datain = ins;
        d_datain = din;
        tick();
        exp_pc = exp_pc + 32'd4;
    endtask

    initial begin
        forever begin
            @(negedge clock);
            while (sbq.size() > 0) begin
                mon_c = sbq.pop_front();
                tests++;
                if (observe(mon_c.sel) !== mon_c.exp) begin
                    fails++;
                    $display("FAIL %s: got %h expected %h",
                             mon_c.name, observe(mon_c.sel), mon_c.exp);
                end
            end
        end
    end

    logic [5:0]  sw_fn  [11];
    logic [4:0]  sw_rs  [11];
    logic [4:0]  sw_rt  [11];
    logic [31:0] sw_exp [11];

    initial begin
        sw_fn = '{FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                  FN_NOR, FN_XOR, FN_XNOR, FN_SLT, FN_SLT};
        sw_rs = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1,
                  5'd1, 5'd1, 5'd1, 5'd2, 5'd1};
        sw_rt = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd2, 5'd2,
                  5'd2, 5'd2, 5'd2, 5'd1, 5'd2};
        sw_exp = '{32'h3CAB, 32'h3CAB, 32'hFFFFC4AB, 32'hFFFFC4AB,
                   32'h0, 32'h3CAB, 32'hFFFFC354, 32'h3CAB,
                   32'hFFFFC354, 32'h0, 32'h1};

        reset    = 1'b1;
        start    = 1'b0;
        i_datain = '0;
        d_datain = '0;
        tick();
        tick();
        reset  = 1'b0;
        exp_pc = 32'h0;
        push("reset_pc", S_PC, 32'h0);
        push("reset_gr1", S_GR + 1, 32'h0);
        push("reset_regc", S_RC, 32'h0);
        start = 1'b1;

        i_datain = enc_i(OP_LW, 5'd0, 5'd1, 16'd1);
        push("lw1_daddr", S_DA, 32'h1);
        push("lw1_we", S_WE, 32'h0);
        exec(i_datain, 32'hAB);
        push("lw1_gr1", S_GR + 1, 32'hAB);
        push("lw1_pc", S_PC, 32'h4);

        exec(enc_i(OP_LW, 5'd0, 5'd2, 16'd2), 32'h3C00);
        push("lw2_gr2", S_GR + 2, 32'h3C00);
        push("lw2_pc", S_PC, 32'h8);

        i_datain = enc_i(OP_SW, 5'd0, 5'd2, 16'd2);
        push("sw_we", S_WE, 32'h1);
        push("sw_daddr", S_DA, 32'h2);
        push("sw_dout", S_DO, 32'h3C00);
        exec(i_datain, 32'h0);
        push("sw_gr2", S_GR + 2, 32'h3C00);
        push("sw_pc", S_PC, 32'hC);

        exec(enc_i(OP_ADDI, 5'd1, 5'd3, 16'd3), 32'h0);
        push("addi_gr3", S_GR + 3, 32'hAE);
        push("addi_rega", S_RA, 32'hAB);
        push("addi_regb", S_RB, 32'h3);
        push("addi_regc", S_RC, 32'hAE);
        exec(enc_i(OP_ADDIU, 5'd1, 5'd4, 16'd3), 32'h0);
        push("addiu_gr4", S_GR + 4, 32'hAE);

        for (int k = 0; k < 11; k++) begin
            exec(enc_r(sw_fn[k], sw_rs[k], sw_rt[k], 5'd3), 32'h0);
            push($sformatf("rtype%0d_gr3", k), S_GR + 3, sw_exp[k]);
        end
        push("rtype_pc", S_PC, exp_pc);

        exec(enc_r(FN_JR, 5'd1, 5'd0, 5'd0), 32'h0);
        exp_pc = 32'hAB;
        push("jr_pc", S_PC, exp_pc);
        push("jr_regc", S_RC, 32'hAB);

        exec(enc_i(OP_ANDI, 5'd1, 5'd5, 16'd4), 32'h0);
        push("andi_gr5", S_GR + 5, 32'h0);
        exec(enc_i(OP_ORI, 5'd1, 5'd6, 16'd4), 32'h0);
        push("ori_gr6", S_GR + 6, 32'hAF);
        push("ori_regb", S_RB, 32'h4);

        exec(enc_i(OP_BEQ, 5'd1, 5'd1, 16'd4), 32'h0);
        exp_pc = exp_pc + 32'd16;
        push("beq_taken_pc", S_PC, 32'hC7);
        exec(enc_i(OP_BNE, 5'd1, 5'd1, 16'd4), 32'h0);
        push("bne_fall_pc", S_PC, 32'hCB);

        exec(enc_j(OP_J, 26'd0), 32'h0);
        exp_pc = 32'h0;
        push("j_pc", S_PC, 32'h0);
        exec(32'hFC00_0000 | enc_i(6'b0, 5'd1, 5'd3, 16'd7), 32'h0);
        push("undef_pc", S_PC, 32'h4);
        push("undef_gr3", S_GR + 3, 32'h1);
        exec(enc_j(OP_JAL, 26'd8), 32'h0);
        exp_pc = 32'h20;
        push("jal_pc", S_PC, 32'h20);
        push("jal_gr31", S_GR + 31, 32'h8);

        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k < 2) i_datain = enc_i(OP_SW, 5'd0, 5'd2, 16'd2);
            else i_datain = enc_i(OP_ADDI, 5'd1, 5'd7, 16'd1);
            push($sformatf("hold%0d_we", k), S_WE, 32'h0);
            tick();
            push($sformatf("hold%0d_pc", k), S_PC, 32'h20);
            push($sformatf("hold%0d_gr1", k), S_GR + 1, 32'hAB);
        end
        push("hold_gr7", S_GR + 7, 32'h0);
        start = 1'b1;

        exec(enc_i(OP_ADDI, 5'd1, 5'd0, 16'd3), 32'h0);
        push("gr0_stays0", S_GR + 0, 32'h0);
        push("gr0_pc", S_PC, 32'h24);
        exec(enc_i(OP_ADDI, 5'd1, 5'd8, 16'hFFFF), 32'h0);
        push("addi_neg_gr8", S_GR + 8, 32'hAA);
        exec(enc_i(OP_BNE, 5'd1, 5'd2, 16'hFFFE), 32'h0);
        push("bne_back_pc", S_PC, 32'h24);

        reset = 1'b1;
        exec(enc_i(OP_ADDI, 5'd1, 5'd9, 16'd1), 32'h0);
        reset = 1'b0;
        start = 1'b0;
        push("mreset_pc", S_PC, 32'h0);
        push("mreset_gr1", S_GR + 1, 32'h0);
        push("mreset_gr9", S_GR + 9, 32'h0);
        push("mreset_gr31", S_GR + 31, 32'h0);
        push("mreset_regc", S_RC, 32'h0);

        tick();
        tick();
        if (sbq.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu.md
Name: cpu

Overview:
- Single-cycle 32-bit MIPS-subset processor core: one instruction fetched, decoded, executed and written back per rising clock edge.
- Sits between an external instruction source, which presents the word at `i_addr` on `i_datain`, and a data memory served through the `d_*` ports.
- Contains the PC, a 32x32 register file `gr[0..31]`, and debug pipeline-view registers `reg_A`, `reg_B`, `reg_C`.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NUM_REGS, 32, register-file depth (5-bit specifiers).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  run enable; when 0, all architectural state holds.
- i_datain  in  32  instruction word for the current PC.
- i_addr  out  32  current PC (equals internal `pc`).
- d_datain  in  32  load data from data memory, valid in the cycle of a lw.
- d_addr  out  32  data address, combinational, = gr[rs] + sext(imm16) for lw/sw, else 0.
- d_we  out  1  combinational, 1 only while a sw is presented and start=1.
- d_dataout  out  32  store data, combinational, = gr[rt] during sw, else 0.

Behaviour:
- Reset (clock edge with reset=1) clears pc, reg_A, reg_B, reg_C and all gr to 0. reset has priority over start. Reset asserted mid-program discards the current instruction.
- Edge with start=1 and reset=0 executes i_datain fully.
- Register writeback:
  - gr0 reads as 0; writes to it are ignored.
  - Register reads are combinational from the pre-edge state.
- Debug registers, captured every executing edge:
  - reg_A <= gr[rs].
  - reg_B <= second ALU operand (gr[rt] for R-type, extended imm16 for I-type).
  - reg_C <= ALU or memory result, or the target address for j/jal/jr.
- R-type (opcode 000000), rd <= f(gr[rs], gr[rt]), selected by funct:
  - add 100000, addu 100001: sum.
  - sub 100010, subu 100011: difference.
  - and 100100, or 100101, xor 100110: bitwise.
  - nor 100111: ~(a|b).
  - xnor 111111: ~(a^b).
  - slt 101010: signed compare; 1 if a<b else 0.
  - jr 001000: pc <= gr[rs] verbatim, no alignment; no register write.
  - Any other funct: no-op.
- I-type, destination rt:
  - addi 001000, addiu 001001: gr[rs] + sext(imm).
  - andi 001100: AND with zext(imm).
  - ori 001111: OR with zext(imm).
  - lw 100011: rt <= d_datain.
  - sw 101011: memory write via d_we/d_dataout/d_addr; no register write.
- Overflow: add/addi/sub wrap modulo 2^32. There are no traps or exceptions; signed and unsigned variants behave identically.
- Branches:
  - beq 000100 taken if gr[rs]==gr[rt]; bne 000101 taken if they differ.
  - Taken: pc <= pc+4+(sext(imm)<<2). Not taken: pc <= pc+4.
- Jumps:
  - j 000010: pc <= {pc_plus4[31:28], addr26, 2'b00}.
  - jal 000011: same target, and gr31 <= pc+4.
- Undefined opcode: no-op, pc <= pc+4.
- Default next pc: pc+4 (wraps at 2^32).
- start=0: no state change, d_we=0.

Decomposition:
- Package cpu_pkg holds:
  - opcode and funct localparams (including the custom xnor funct 111111 and ori=001111);
  - an ALU-op enum;
  - the register-index width.
- One sub-module, cpu_alu: combinational, takes a, b and alu_op, returns the 32-bit result and a zero flag. Register file, decode and PC logic stay in cpu.

Test Plan:
- Reset then loads. Apply reset, then start=1.
  - lw rs=gr0 rt=gr1 imm=1 with d_datain=0xAB -> gr1=0xAB, d_addr=1.
  - lw rt=gr2 imm=2 with d_datain=0x3C00 -> gr2=0x3C00.
  - pc goes 0 -> 4 -> 8.
- Store: sw rs=gr0 rt=gr2 imm=2 -> d_we=1, d_addr=2, d_dataout=0x3C00; no register changes.
- Immediate add: addi rs=gr1 rt=gr3 imm=3 -> gr3=0xAE; addiu gives the same.
- R-type sweep with rs=gr1 (0xAB), rt=gr2 (0x3C00), rd=gr3:
  - add/addu=0x3CAB, sub/subu=0xFFFFC4AB.
  - and=0x0, or=0x3CAB, nor=0xFFFFC354, xor=0x3CAB, xnor=0xFFFFC354.
  - slt rs=gr2, rt=gr1 -> 0; swapped operands -> 1.
- Control flow:
  - jr gr1 -> pc=0xAB.
  - andi gr1 with imm 4 -> 0x0; ori gr1 with imm 4 -> 0xAF.
  - beq with equal operands and imm=4 -> pc+20; bne with the same operands -> pc+4.
  - j 0 -> pc=0; jal 8 from pc=P -> pc=0x20, gr31=P+4.
- Hold and gr0:
  - start=0 for 3 cycles -> pc and gr unchanged, d_we=0.
  - addi targeting gr0 -> gr0 stays 0.
  - reset asserted mid-run -> pc=0 and all registers 0 on the next edge.
